// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//  Shared definitions for the 32x32 RGB LED matrix frame buffer path.
//  - COLS / ROWS / COL_W / ADDR_W : frame geometry and RAM address width
//  - rgb_t                        : packed {r,g,b} pixel
//  - fbw_state_t                  : write scheduler FSM states
//  - pix_adr(x, y)                : frame RAM address of a pixel ({y, x})
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int COLS   = 32;
    localparam int ROWS   = 32;
    localparam int COL_W  = $clog2(COLS);
    localparam int ADDR_W = $clog2(COLS * ROWS);

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WRITE,
        RELEASE
    } fbw_state_t;

    // Row-major address: y*32 + x. With 32 columns this is plain concatenation,
    // so rows 16..31 naturally fall into the upper half of the RAM.
    function automatic logic [ADDR_W-1:0] pix_adr(input logic [COL_W-1:0] x,
                                                  input logic [COL_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/fbw_fifo.sv
// -----------------------------------------------------------------------------
// fbw_fifo
//  Small synchronous FIFO holding pending frame RAM writes.
//  Ports:
//   clk, reset      clock, asynchronous active-high reset (pointers/count)
//   push, push_data write side; a push while full is dropped
//   pop             read side; a pop while empty is ignored
//   head            entry at the read pointer (valid when !empty)
//   full, empty     derived from the registered count only
//   count           number of entries held (0..DEPTH)
//  DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module fbw_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// -----------------------------------------------------------------------------
// fb_write_scheduler
//  Queues host pixel writes and issues them to the shared R/G/B frame RAMs
//  only while the scan controller has released the address bus (slot_open).
//  Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_valid/wr_ready   host write handshake; wr_x, wr_y, wr_rgb = pixel
//   slot_open           scan controller is not using the RAM address bus
//   scan_sel            1 = scan address drives RAM, 0 = this block drives it
//   mem_we/adr/din      frame RAM write port (registered)
//   pending             number of queued host writes
//   clr_req, clr_busy   (FB_CLEAR_EN only) full-frame clear to 0
//  Optional feature macro: FB_CLEAR_EN adds a sweep that clears the whole
//  frame, with priority over queued host writes.
// -----------------------------------------------------------------------------
module fb_write_scheduler #(
    parameter int ADDR_W     = 10,
    parameter int COL_W      = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_MAX   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [COL_W-1:0]              wr_x,
    input  logic [COL_W-1:0]              wr_y,
    input  logic [2:0]                    wr_rgb,
    input  logic                          slot_open,
`ifdef FB_CLEAR_EN
    input  logic                          clr_req,
    output logic                          clr_busy,
`endif
    output logic                          scan_sel,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_adr,
    output logic [2:0]                    mem_din,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    import matrix_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W   = ADDR_W + 3;
    localparam int BURST_W = $clog2(SLOT_MAX + 1);

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic [ENT_W-1:0] push_entry;
    logic [ENT_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // FSM state and registered outputs
    fbw_state_t          state_q, state_d;
    logic                scan_sel_q, scan_sel_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
    rgb_t                mem_din_q, mem_din_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    // Set once a window has been released; keeps a long slot from starting a
    // second burst, so SLOT_MAX really is a per-window limit.
    logic                done_q, done_d;

    // Source selection for the next ARM
    logic                have_work;
    logic [ADDR_W-1:0]   next_adr;
    rgb_t                next_din;

`ifdef FB_CLEAR_EN
    logic                clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]   clr_adr_q, clr_adr_d;
    logic                src_clr_q, src_clr_d;   // current ARM/WRITE entry is a clear write
    logic                clr_last;               // WRITE of the final sweep address
    logic                use_clr;

    assign clr_last  = clr_busy_q && (state_q == WRITE) && src_clr_q && (mem_adr_q == '1);
    assign use_clr   = clr_busy_q && !clr_last;
    assign have_work = use_clr || !fifo_empty;
    assign next_adr  = use_clr ? clr_adr_q : fifo_head[ENT_W-1:3];
    assign next_din  = use_clr ? rgb_t'(3'b000) : rgb_t'(fifo_head[2:0]);
    assign wr_ready  = !fifo_full && !clr_busy_q;
    assign clr_busy  = clr_busy_q;
`else
    assign have_work = !fifo_empty;
    assign next_adr  = fifo_head[ENT_W-1:3];
    assign next_din  = rgb_t'(fifo_head[2:0]);
    assign wr_ready  = !fifo_full;
`endif

    assign fifo_push  = wr_valid && wr_ready;
    assign push_entry = {ADDR_W'(pix_adr(wr_x, wr_y)), wr_rgb};

    fbw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        scan_sel_d = scan_sel_q;
        mem_we_d   = 1'b0;
        mem_adr_d  = mem_adr_q;
        mem_din_d  = mem_din_q;
        burst_d    = burst_q;
        done_d     = done_q;
        fifo_pop   = 1'b0;
`ifdef FB_CLEAR_EN
        src_clr_d  = src_clr_q;
        clr_busy_d = clr_busy_q;
        clr_adr_d  = clr_adr_q;
        if (clr_req && !clr_busy_q) begin
            clr_busy_d = 1'b1;
            clr_adr_d  = '0;
        end
        if (clr_last) begin
            clr_busy_d = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                scan_sel_d = 1'b1;
                if (have_work && slot_open && !done_q) begin
                    state_d    = ARM;
                    scan_sel_d = 1'b0;
                    mem_adr_d  = next_adr;
                    mem_din_d  = next_din;
`ifdef FB_CLEAR_EN
                    src_clr_d  = use_clr;
`endif
                end
            end
            ARM: begin
                if (slot_open) begin
                    state_d  = WRITE;
                    mem_we_d = 1'b1;
                    burst_d  = burst_q + 1'b1;
                    // The entry leaves the queue as the write is issued, so an
                    // abort in ARM never loses it.
`ifdef FB_CLEAR_EN
                    if (src_clr_q) begin
                        clr_adr_d = clr_adr_q + 1'b1;
                    end else begin
                        fifo_pop = 1'b1;
                    end
`else
                    fifo_pop = 1'b1;
`endif
                end else begin
                    state_d    = IDLE;
                    scan_sel_d = 1'b1;
                end
            end
            WRITE: begin
                // burst_q already counts the write in progress.
                if (slot_open && have_work && (burst_q < BURST_W'(SLOT_MAX))) begin
                    state_d   = ARM;
                    mem_adr_d = next_adr;
                    mem_din_d = next_din;
`ifdef FB_CLEAR_EN
                    src_clr_d = use_clr;
`endif
                end else begin
                    state_d    = RELEASE;
                    scan_sel_d = 1'b1;
                    burst_d    = '0;
                    done_d     = slot_open;
                end
            end
            RELEASE: begin
                state_d    = IDLE;
                scan_sel_d = 1'b1;
                burst_d    = '0;
            end
            default: begin
                state_d    = IDLE;
                scan_sel_d = 1'b1;
            end
        endcase

        // A closed slot ends the window: the next opening starts a fresh burst.
        if (!slot_open) begin
            burst_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            scan_sel_q <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_din_q  <= '0;
            burst_q    <= '0;
            done_q     <= 1'b0;
`ifdef FB_CLEAR_EN
            src_clr_q  <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_adr_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            scan_sel_q <= scan_sel_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_din_q  <= mem_din_d;
            burst_q    <= burst_d;
            done_q     <= done_d;
`ifdef FB_CLEAR_EN
            src_clr_q  <= src_clr_d;
            clr_busy_q <= clr_busy_d;
            clr_adr_q  <= clr_adr_d;
`endif
        end
    end

    assign scan_sel = scan_sel_q;
    assign mem_we   = mem_we_q;
    assign mem_adr  = mem_adr_q;
    assign mem_din  = mem_din_q;
    assign pending  = fifo_count;

endmodule
